// File: rtl/board_sweep_reader_if.sv
// Read port shared by the placement and shot memories, plus the gameplay
// write-activity flag the sweep engine must yield to.
interface board_sweep_reader_if;
  logic [6:0] rd_addr;
  logic       place_oe;
  logic       shoot_oe;
  logic [1:0] place_rdata;
  logic [1:0] shoot_rdata;
  logic       wr_req;

  modport master (
    output rd_addr, place_oe, shoot_oe,
    input  place_rdata, shoot_rdata, wr_req
  );

  modport slave (
    input  rd_addr, place_oe, shoot_oe,
    output place_rdata, shoot_rdata, wr_req
  );
endinterface

// File: rtl/board_sweep_reader.sv
// Sweeps both 100-cell boards, streams each cell pair with its address and
// publishes ships-left / hits / misses tallies plus game-over per sweep.
module board_sweep_reader #(
  parameter int unsigned CELLS = 100,
  parameter int unsigned CNT_W = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  board_sweep_reader_if.master    mem,
  output logic                    cell_valid,
  output logic [6:0]              cell_addr,
  output logic [1:0]              cell_place,
  output logic [1:0]              cell_shoot,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        ships_left,
  output logic [CNT_W-1:0]        hits,
  output logic [CNT_W-1:0]        misses,
  output logic                    game_over
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  localparam logic [6:0] LAST_ADDR = 7'(CELLS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [6:0]         addr_q, addr_d;
  logic               pend_q, pend_d;
  logic [6:0]         pend_addr_q, pend_addr_d;
  logic               cell_valid_q, cell_valid_d;
  logic [6:0]         cell_addr_q, cell_addr_d;
  logic [1:0]         cell_place_q, cell_place_d;
  logic [1:0]         cell_shoot_q, cell_shoot_d;
  logic [CNT_W-1:0]   run_ships_q, run_ships_d;
  logic [CNT_W-1:0]   run_hits_q, run_hits_d;
  logic [CNT_W-1:0]   run_misses_q, run_misses_d;
  logic               ship_seen_q, ship_seen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   ships_left_q, ships_left_d;
  logic [CNT_W-1:0]   hits_q, hits_d;
  logic [CNT_W-1:0]   misses_q, misses_d;
  logic               game_over_q, game_over_d;
  logic               issue;

  // oe must drop in the same cycle as wr_req, so it cannot be registered.
  assign issue        = (state_q == S_SWEEP) && !mem.wr_req;
  assign mem.place_oe = issue;
  assign mem.shoot_oe = issue;
  assign mem.rd_addr  = addr_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pend_d       = 1'b0;
    pend_addr_d  = pend_addr_q;
    cell_valid_d = 1'b0;
    cell_addr_d  = cell_addr_q;
    cell_place_d = cell_place_q;
    cell_shoot_d = cell_shoot_q;
    run_ships_d  = run_ships_q;
    run_hits_d   = run_hits_q;
    run_misses_d = run_misses_q;
    ship_seen_d  = ship_seen_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ships_left_d = ships_left_q;
    hits_d       = hits_q;
    misses_d     = misses_q;
    game_over_d  = game_over_q;

    if (pend_q) begin
      cell_valid_d = 1'b1;
      cell_addr_d  = pend_addr_q;
      cell_place_d = mem.place_rdata;
      cell_shoot_d = mem.shoot_rdata;
      if (mem.place_rdata != 2'b00) begin
        ship_seen_d = 1'b1;
        if (!mem.shoot_rdata[1]) run_ships_d = sat_inc(run_ships_q);
      end
      if (mem.shoot_rdata[1])        run_hits_d   = sat_inc(run_hits_q);
      if (mem.shoot_rdata == 2'b01)  run_misses_d = sat_inc(run_misses_q);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SWEEP;
          addr_d       = '0;
          run_ships_d  = '0;
          run_hits_d   = '0;
          run_misses_d = '0;
          ship_seen_d  = 1'b0;
          busy_d       = 1'b1;
        end
      end
      S_SWEEP: begin
        if (issue) begin
          pend_d      = 1'b1;
          pend_addr_d = addr_q;
          if (addr_q == LAST_ADDR) state_d = S_DRAIN;
          else                     addr_d  = addr_q + 7'd1;
        end
      end
      // Publishing from the DRAIN-cycle totals lets the new tallies appear
      // in the DONE cycle together with the done pulse.
      S_DRAIN: begin
        state_d      = S_DONE;
        done_d       = 1'b1;
        ships_left_d = run_ships_d;
        hits_d       = run_hits_d;
        misses_d     = run_misses_d;
        game_over_d  = ship_seen_d && (run_ships_d == '0);
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      cell_valid_q <= 1'b0;
      cell_addr_q  <= '0;
      cell_place_q <= '0;
      cell_shoot_q <= '0;
      run_ships_q  <= '0;
      run_hits_q   <= '0;
      run_misses_q <= '0;
      ship_seen_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ships_left_q <= '0;
      hits_q       <= '0;
      misses_q     <= '0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      cell_valid_q <= cell_valid_d;
      cell_addr_q  <= cell_addr_d;
      cell_place_q <= cell_place_d;
      cell_shoot_q <= cell_shoot_d;
      run_ships_q  <= run_ships_d;
      run_hits_q   <= run_hits_d;
      run_misses_q <= run_misses_d;
      ship_seen_q  <= ship_seen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ships_left_q <= ships_left_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      game_over_q  <= game_over_d;
    end
  end

  assign cell_valid = cell_valid_q;
  assign cell_addr  = cell_addr_q;
  assign cell_place = cell_place_q;
  assign cell_shoot = cell_shoot_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ships_left = ships_left_q;
  assign hits       = hits_q;
  assign misses     = misses_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_board_sweep_reader.sv
// Directed bench for board_sweep_reader: memory model, stream monitor and
// hand-computed tallies/timing for each board scenario.
module tb_board_sweep_reader;
  localparam int unsigned CNT_W = 7;

  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  board_sweep_reader_if mem_if();

  logic             cell_valid;
  logic [6:0]       cell_addr;
  logic [1:0]       cell_place, cell_shoot;
  logic             busy, done, game_over;
  logic [CNT_W-1:0] ships_left, hits, misses;

  board_sweep_reader #(.CELLS(100), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem        (mem_if),
    .cell_valid (cell_valid),
    .cell_addr  (cell_addr),
    .cell_place (cell_place),
    .cell_shoot (cell_shoot),
    .busy       (busy),
    .done       (done),
    .ships_left (ships_left),
    .hits       (hits),
    .misses     (misses),
    .game_over  (game_over)
  );

  logic [1:0] place_mem [0:127];
  logic [1:0] shoot_mem [0:127];

  always @(posedge clk) begin
    if (mem_if.place_oe) mem_if.place_rdata <= place_mem[mem_if.rd_addr];
    if (mem_if.shoot_oe) mem_if.shoot_rdata <= shoot_mem[mem_if.rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   c0;
  logic mon_clr;
  int   valid_cnt, first_rel, last_rel, order_err, data_err;
  int   oe_viol, a40_cnt, done_cnt, done_rel, exp_next;

  always @(negedge clk) begin
    if (mon_clr) begin
      valid_cnt = 0; first_rel = 0; last_rel = 0; order_err = 0; data_err = 0;
      oe_viol = 0; a40_cnt = 0; done_cnt = 0; done_rel = 0; exp_next = 0;
    end else begin
      if ((mem_if.place_oe || mem_if.shoot_oe) && mem_if.wr_req) oe_viol++;
      if (mem_if.place_oe != mem_if.shoot_oe) oe_viol++;
      if (mem_if.place_oe && mem_if.rd_addr == 7'd40) a40_cnt++;
      if (cell_valid) begin
        if (valid_cnt == 0) first_rel = cyc - c0;
        last_rel = cyc - c0;
        if (cell_addr != 7'(exp_next)) order_err++;
        if (cell_place != place_mem[cell_addr] || cell_shoot != shoot_mem[cell_addr]) data_err++;
        exp_next++;
        valid_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - c0;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({busy, done, cell_valid, mem_if.place_oe, mem_if.shoot_oe, mem_if.rd_addr,
                cell_addr, cell_place, cell_shoot, ships_left, hits, misses, game_over});
  endfunction

  // kind 0: empty; 1: 17 ships, 5 hit, 8 water misses; 2: 17 ships all hit, 3 misses
  task automatic load_board(input int kind);
    for (int i = 0; i < 128; i++) begin
      place_mem[i] = 2'b00;
      shoot_mem[i] = 2'b00;
    end
    if (kind != 0) begin
      for (int i = 0; i < 17; i++) place_mem[i] = 2'((i % 3) + 1);
    end
    if (kind == 1) begin
      for (int i = 0; i < 5; i++)   shoot_mem[i] = (i % 2 == 1) ? 2'b11 : 2'b10;
      for (int i = 90; i < 98; i++) shoot_mem[i] = 2'b01;
    end
    if (kind == 2) begin
      for (int i = 0; i < 17; i++) shoot_mem[i] = (i % 2 == 1) ? 2'b11 : 2'b10;
      shoot_mem[50] = 2'b01;
      shoot_mem[51] = 2'b01;
      shoot_mem[99] = 2'b01;
    end
  endtask

  int mid_s, mid_h, mid_m;
  int pub_s = 0, pub_h = 0, pub_m = 0;

  task automatic run_sweep(input int wr_len, input int re_a, input int re_b, input int rst_at);
    int wr_left;
    int rel;
    mid_s = -1; mid_h = -1; mid_m = -1;
    @(posedge clk); #1;
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
    start = 1'b1;
    c0 = cyc;
    wr_left = wr_len;
    for (int k = 0; k < 125; k++) begin
      @(posedge clk); #1;
      rel = cyc - c0;
      start = (rel == re_a) || (rel == re_b);
      mem_if.wr_req = (wr_left > 0) && busy && (mem_if.rd_addr == 7'd40);
      if (mem_if.wr_req) wr_left--;
      if (rel == 50) begin
        mid_s = int'(ships_left); mid_h = int'(hits); mid_m = int'(misses);
      end
      if (rel == rst_at) begin
        reset = 1'b0;
        #1;
        break;
      end
    end
    start = 1'b0;
    mem_if.wr_req = 1'b0;
  endtask

  task automatic expect_sweep(input string tag, input int done_at,
                              input int es, input int eh, input int em, input int ego);
    check({tag, "_done_cnt"},    done_cnt, 1);
    check({tag, "_done_cycle"},  done_rel, done_at);
    check({tag, "_valid_cnt"},   valid_cnt, 100);
    check({tag, "_first_valid"}, first_rel, 3);
    check({tag, "_last_valid"},  last_rel, done_at);
    check({tag, "_addr_order"},  order_err, 0);
    check({tag, "_cell_data"},   data_err, 0);
    check({tag, "_oe_vs_wr"},    oe_viol, 0);
    check({tag, "_mid_hold"},    mid_s * 65536 + mid_h * 256 + mid_m,
                                 pub_s * 65536 + pub_h * 256 + pub_m);
    check({tag, "_ships_left"},  ships_left, es);
    check({tag, "_hits"},        hits, eh);
    check({tag, "_misses"},      misses, em);
    check({tag, "_game_over"},   game_over, ego);
    check({tag, "_busy_end"},    busy, 0);
    pub_s = es; pub_h = eh; pub_m = em;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    mem_if.wr_req = 1'b0;
    mon_clr = 1'b1;
    c0 = 0;
    load_board(0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs_vec(), 64'd0);
    reset = 1'b1;

    load_board(0); run_sweep(0, -1, -1, -1);
    expect_sweep("empty", 102, 0, 0, 0, 0);

    load_board(1); run_sweep(0, -1, -1, -1);
    expect_sweep("partial", 102, 12, 5, 8, 0);

    load_board(2); run_sweep(0, -1, -1, -1);
    expect_sweep("all_hit", 102, 0, 17, 3, 1);

    load_board(1); run_sweep(4, -1, -1, -1);
    expect_sweep("wr_stall", 106, 12, 5, 8, 0);
    check("wr_stall_addr40_reads", a40_cnt, 1);

    load_board(2); run_sweep(0, 50, 102, -1);
    expect_sweep("restart_ignored", 102, 0, 17, 3, 1);

    load_board(0); run_sweep(0, -1, -1, -1);
    expect_sweep("second_sweep", 102, 0, 0, 0, 0);

    load_board(2); run_sweep(0, -1, -1, 60);
    check("midreset_outs_now", outs_vec(), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midreset_outs_hold", outs_vec(), 64'd0);
    check("midreset_no_done", done_cnt, 0);
    reset = 1'b1;
    pub_s = 0; pub_h = 0; pub_m = 0;

    load_board(0); run_sweep(0, -1, -1, -1);
    expect_sweep("after_reset", 102, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
